// File: rtl/fft_peak_detect_if.sv
// Magnitude stream from fft_process into the peak detector.
// Each valid beat carries one bin and is accepted unconditionally (no ready).
interface fft_peak_detect_if #(
  parameter int LOG2N = 10
) ();
  logic [27:0]      magnitude;
  logic [LOG2N-1:0] bin_index;
  logic             magnitude_valid;

  modport master (
    output magnitude,
    output bin_index,
    output magnitude_valid
  );

  modport slave (
    input magnitude,
    input bin_index,
    input magnitude_valid
  );
endinterface

// File: rtl/fft_peak_detect.sv
// Streaming spectral peak finder: tracks the largest bin in the lower half of a
// frame with its neighbours, then reports the peak bin, magnitudes and Hz once per frame.
module fft_peak_detect #(
  parameter int          N         = 1024,
  parameter int          LOG2N     = 10,
  parameter int          MIN_BIN   = 2,
  parameter logic [27:0] THRESH    = 28'h0100000,
  parameter logic [31:0] FREQ_STEP = 32'd32000000
) (
  input  logic                 clk,
  input  logic                 rst,
  fft_peak_detect_if.slave     s_in,
  output logic [LOG2N-1:0]     o_peak_bin,
  output logic [27:0]          o_peak_mag,
  output logic [27:0]          o_left_mag,
  output logic [27:0]          o_right_mag,
  output logic [19:0]          o_peak_freq_hz,
  output logic                 o_peak_found,
  output logic                 o_result_valid,
  output logic                 o_frame_error,
  output logic                 o_busy
);

  localparam logic [LOG2N-1:0] LP_BIN_ZERO = {LOG2N{1'b0}};
  localparam logic [LOG2N-1:0] LP_BIN_ONE  = {{(LOG2N-1){1'b0}}, 1'b1};
  localparam logic [LOG2N-1:0] LP_BIN_MIN  = LOG2N'(MIN_BIN);
  localparam logic [LOG2N-1:0] LP_BIN_TOP  = LOG2N'(N / 2 - 1);
  localparam logic [LOG2N-1:0] LP_BIN_LAST = LOG2N'(N - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_SCAN = 2'd1,
    ST_CALC = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [LOG2N-1:0] r_expected;
  logic             r_have_max;
  logic [27:0]      r_max_mag;
  logic [LOG2N-1:0] r_max_bin;
  logic [27:0]      r_left;
  logic [27:0]      r_right;
  logic             r_arm;
  logic [27:0]      r_prev;
  logic [19:0]      r_freq_calc;

  logic             w_start;
  logic             w_restart;
  logic             w_take;
  logic             w_err;
  logic             w_last;
  logic             w_in_range;
  logic             w_replace;
  logic             w_frame_begin;
  logic [19:0]      w_freq;

  // State register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  // Next state plus beat classification: start, restart, in-sequence take, or error.
  always_comb begin
    w_next    = r_state;
    w_start   = 1'b0;
    w_restart = 1'b0;
    w_take    = 1'b0;
    w_err     = 1'b0;
    w_last    = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (s_in.magnitude_valid && (s_in.bin_index == LP_BIN_ZERO)) begin
          w_start = 1'b1;
          w_next  = ST_SCAN;
        end else begin
          w_next  = ST_IDLE;
        end
      end
      ST_SCAN: begin
        if (!s_in.magnitude_valid) begin
          w_next = ST_SCAN;
        end else if (s_in.bin_index == LP_BIN_ZERO) begin
          w_restart = 1'b1;
          w_err     = 1'b1;
          w_next    = ST_SCAN;
        end else if (s_in.bin_index != r_expected) begin
          w_err  = 1'b1;
          w_next = ST_IDLE;
        end else if (s_in.bin_index == LP_BIN_LAST) begin
          w_take = 1'b1;
          w_last = 1'b1;
          w_next = ST_CALC;
        end else begin
          w_take = 1'b1;
          w_next = ST_SCAN;
        end
      end
      ST_CALC: begin
        w_next = ST_IDLE;
      end
      default: begin
        w_next = ST_IDLE;
      end
    endcase
  end

  assign w_frame_begin = w_start | w_restart;
  assign w_in_range    = w_take && (s_in.bin_index >= LP_BIN_MIN) && (s_in.bin_index <= LP_BIN_TOP);
  assign w_replace     = w_in_range && (!r_have_max || (s_in.magnitude > r_max_mag));
  assign w_freq        = 20'((48'(r_max_bin) * 48'(FREQ_STEP)) >> 16);

  // Running max search; left comes from the one-deep history, right from the next in-range beat.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_expected  <= LP_BIN_ZERO;
      r_have_max  <= 1'b0;
      r_max_mag   <= 28'd0;
      r_max_bin   <= LP_BIN_ZERO;
      r_left      <= 28'd0;
      r_right     <= 28'd0;
      r_arm       <= 1'b0;
      r_prev      <= 28'd0;
      r_freq_calc <= 20'd0;
    end else begin
      if (w_frame_begin) begin
        r_expected <= LP_BIN_ONE;
        r_have_max <= 1'b0;
        r_max_mag  <= 28'd0;
        r_max_bin  <= LP_BIN_ZERO;
        r_left     <= 28'd0;
        r_right    <= 28'd0;
        r_arm      <= 1'b0;
        r_prev     <= s_in.magnitude;
      end else if (w_take) begin
        r_expected <= r_expected + LP_BIN_ONE;
        r_prev     <= s_in.magnitude;
        if (w_replace) begin
          r_have_max <= 1'b1;
          r_max_mag  <= s_in.magnitude;
          r_max_bin  <= s_in.bin_index;
          r_left     <= r_prev;
          r_right    <= 28'd0;
          r_arm      <= (s_in.bin_index != LP_BIN_TOP);
        end else if (w_in_range && r_arm) begin
          r_right <= s_in.magnitude;
          r_arm   <= 1'b0;
        end
      end
      // Peak bin is final once the last beat arrives, so the multiply is registered here.
      if (w_last) begin
        r_freq_calc <= w_freq;
      end
    end
  end

  // Result outputs load together in CALC and hold until the next frame completes.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      o_peak_bin     <= LP_BIN_ZERO;
      o_peak_mag     <= 28'd0;
      o_left_mag     <= 28'd0;
      o_right_mag    <= 28'd0;
      o_peak_freq_hz <= 20'd0;
      o_peak_found   <= 1'b0;
      o_result_valid <= 1'b0;
      o_frame_error  <= 1'b0;
      o_busy         <= 1'b0;
    end else begin
      o_result_valid <= (r_state == ST_CALC);
      o_frame_error  <= w_err;
      o_busy         <= (w_next != ST_IDLE);
      if (r_state == ST_CALC) begin
        o_peak_bin     <= r_max_bin;
        o_peak_mag     <= r_max_mag;
        o_left_mag     <= r_left;
        o_right_mag    <= r_right;
        o_peak_freq_hz <= r_freq_calc;
        o_peak_found   <= (r_max_mag >= THRESH);
      end
    end
  end

endmodule

// File: tb/tb_fft_peak_detect.sv
// Self-checking bench for fft_peak_detect: frames are streamed beat by beat and
// results compared against a simple array-scan model of the peak search.
module tb_fft_peak_detect;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  fft_peak_detect_if #(.LOG2N(10)) u_if ();

  logic [9:0]  o_peak_bin;
  logic [27:0] o_peak_mag, o_left_mag, o_right_mag;
  logic [19:0] o_peak_freq_hz;
  logic        o_peak_found, o_result_valid, o_frame_error, o_busy;

  fft_peak_detect #(
    .N(1024), .LOG2N(10), .MIN_BIN(2), .THRESH(28'h0100000), .FREQ_STEP(32'd32000000)
  ) u_dut (
    .clk(clk), .rst(rst), .s_in(u_if),
    .o_peak_bin(o_peak_bin), .o_peak_mag(o_peak_mag), .o_left_mag(o_left_mag),
    .o_right_mag(o_right_mag), .o_peak_freq_hz(o_peak_freq_hz), .o_peak_found(o_peak_found),
    .o_result_valid(o_result_valid), .o_frame_error(o_frame_error), .o_busy(o_busy)
  );

  int errors = 0;
  int checks = 0;
  int g_viol = 0;
  int g_rv_count = 0;
  bit g_in_frame = 1'b0;

  logic [27:0] fr [0:1023];

  logic [9:0]  exp_bin;
  logic [27:0] exp_peak, exp_left, exp_right;
  logic [19:0] exp_freq;
  logic        exp_found;

  logic        obs_rv1, obs_rv2, obs_rv3, obs_busy1, obs_busy2;
  logic [9:0]  obs_bin;
  logic [27:0] obs_peak, obs_left, obs_right;
  logic [19:0] obs_freq;
  logic        obs_found;

  // One beat (or idle cycle) per call; outputs are observed at the negedge first.
  task automatic drive(input logic v, input logic [9:0] b, input logic [27:0] m);
    @(negedge clk);
    if (o_result_valid) g_rv_count++;
    if (g_in_frame && (!o_busy || o_result_valid || o_frame_error)) g_viol++;
    u_if.magnitude_valid = v;
    u_if.bin_index       = b;
    u_if.magnitude       = m;
  endtask

  task automatic run_frame(input int gap_max, input int start);
    g_viol     = 0;
    g_in_frame = (start > 0);
    for (int b = start; b < 1024; b++) begin
      if (gap_max > 0) repeat ($urandom_range(0, gap_max)) drive(1'b0, 10'd0, 28'd0);
      drive(1'b1, 10'(b), fr[b]);
      g_in_frame = 1'b1;
    end
    g_in_frame = 1'b0;
    drive(1'b0, 10'd0, 28'd0);
    obs_rv1 = o_result_valid; obs_busy1 = o_busy;
    drive(1'b0, 10'd0, 28'd0);
    obs_rv2 = o_result_valid; obs_busy2 = o_busy;
    obs_bin = o_peak_bin; obs_peak = o_peak_mag; obs_left = o_left_mag;
    obs_right = o_right_mag; obs_freq = o_peak_freq_hz; obs_found = o_peak_found;
    drive(1'b0, 10'd0, 28'd0);
    obs_rv3 = o_result_valid;
  endtask

  // Reference: plain scan of bins 2..511, first strict maximum wins.
  task automatic compute_expected();
    int pb;
    logic [27:0] pm;
    pb = 2;
    pm = fr[2];
    for (int b = 3; b <= 511; b++) begin
      if (fr[b] > pm) begin
        pm = fr[b];
        pb = b;
      end
    end
    exp_bin   = 10'(pb);
    exp_peak  = pm;
    exp_left  = fr[pb-1];
    exp_right = (pb == 511) ? 28'd0 : fr[pb+1];
    exp_freq  = 20'((64'(pb) * 64'd32000000) >> 16);
    exp_found = (pm >= 28'h0100000);
  endtask

  task automatic test_reset();
    repeat (2) @(negedge clk);
    checks++;
    if ({o_peak_bin, o_peak_mag, o_left_mag, o_right_mag, o_peak_freq_hz, o_peak_found,
         o_result_valid, o_frame_error, o_busy} !== 125'd0) begin
      errors++;
      $display("FAIL reset_outputs got bin=%0d mag=%h rv=%b fe=%b busy=%b expected all zero",
               o_peak_bin, o_peak_mag, o_result_valid, o_frame_error, o_busy);
    end
    rst = 1'b0;
    drive(1'b1, 10'd5, 28'h123);
    drive(1'b1, 10'd6, 28'h456);
    drive(1'b0, 10'd0, 28'd0);
    checks++;
    if (o_busy !== 1'b0 || o_frame_error !== 1'b0 || g_rv_count !== 0) begin
      errors++;
      $display("FAIL idle_ignore got busy=%b fe=%b rv_count=%0d expected 0 0 0",
               o_busy, o_frame_error, g_rv_count);
    end
  endtask

  task automatic test_basic();
    for (int b = 0; b < 1024; b++)
      fr[b] = (b == 123) ? 28'h2000000 : (b == 122) ? 28'h0800000 : (b == 124) ? 28'h0600000 : 28'h100;
    run_frame(0, 0);
    checks++;
    if ({obs_rv1, obs_rv2, obs_rv3, obs_busy1, obs_busy2} !== 5'b01010) begin
      errors++;
      $display("FAIL basic_timing got rv=%b%b%b busy=%b%b expected rv=010 busy=10",
               obs_rv1, obs_rv2, obs_rv3, obs_busy1, obs_busy2);
    end
    checks++;
    if (obs_bin !== 10'd123 || obs_left !== 28'h0800000 || obs_right !== 28'h0600000 ||
        obs_peak !== 28'h2000000 || obs_freq !== 20'd60058 || obs_found !== 1'b1) begin
      errors++;
      $display("FAIL basic_result got bin=%0d peak=%h left=%h right=%h hz=%0d found=%b expected 123 2000000 0800000 0600000 60058 1",
               obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found);
    end
    checks++;
    if (g_viol !== 0) begin
      errors++;
      $display("FAIL basic_busy got violations=%0d expected 0", g_viol);
    end
  endtask

  task automatic test_gaps();
    run_frame(5, 0);
    compute_expected();
    checks++;
    if ({obs_rv1, obs_rv2, obs_rv3} !== 3'b010 ||
        {obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found} !==
        {exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found}) begin
      errors++;
      $display("FAIL gaps_result got rv=%b%b%b bin=%0d hz=%0d expected rv=010 bin=%0d hz=%0d",
               obs_rv1, obs_rv2, obs_rv3, obs_bin, obs_freq, exp_bin, exp_freq);
    end
    checks++;
    if (g_viol !== 0 || obs_busy1 !== 1'b1 || obs_busy2 !== 1'b0) begin
      errors++;
      $display("FAIL gaps_busy got violations=%0d busy=%b%b expected 0 and 10", g_viol, obs_busy1, obs_busy2);
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      for (int b = 0; b < 1024; b++) fr[b] = 28'($urandom());
      run_frame(2, 0);
      compute_expected();
      checks++;
      if ({obs_rv1, obs_rv2, obs_rv3} !== 3'b010 ||
          {obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found} !==
          {exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found} || g_viol !== 0) begin
        errors++;
        $display("FAIL random_frame%0d got rv=%b%b%b bin=%0d peak=%h left=%h right=%h hz=%0d found=%b viol=%0d expected bin=%0d peak=%h left=%h right=%h hz=%0d found=%b",
                 f, obs_rv1, obs_rv2, obs_rv3, obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found,
                 g_viol, exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found);
      end
    end
  endtask

  task automatic test_exclusion();
    for (int b = 0; b < 1024; b++) fr[b] = 28'h50;
    fr[1]   = 28'hFFFFFFF;
    fr[700] = 28'hFFFFFFF;
    run_frame(1, 0);
    checks++;
    if (obs_rv2 !== 1'b1 || obs_bin !== 10'd2 || obs_found !== 1'b0 ||
        obs_left !== 28'hFFFFFFF || obs_right !== 28'h50 || obs_peak !== 28'h50) begin
      errors++;
      $display("FAIL exclusion got rv=%b bin=%0d found=%b left=%h right=%h peak=%h expected 1 2 0 fffffff 50 50",
               obs_rv2, obs_bin, obs_found, obs_left, obs_right, obs_peak);
    end
  endtask

  task automatic test_ties_edge();
    for (int b = 0; b < 1024; b++) fr[b] = 28'(b);
    fr[40] = 28'h300000;
    fr[90] = 28'h300000;
    run_frame(0, 0);
    checks++;
    if (obs_rv2 !== 1'b1 || obs_bin !== 10'd40 || obs_freq !== 20'd19531 ||
        obs_left !== 28'd39 || obs_right !== 28'd41 || obs_found !== 1'b1) begin
      errors++;
      $display("FAIL tie_lowest got rv=%b bin=%0d hz=%0d left=%h right=%h found=%b expected 1 40 19531 27 29 1",
               obs_rv2, obs_bin, obs_freq, obs_left, obs_right, obs_found);
    end
    for (int b = 0; b < 1024; b++) fr[b] = 28'($urandom_range(0, 4095));
    fr[511] = 28'h0400000;
    fr[512] = 28'h0ABCDEF;
    run_frame(0, 0);
    compute_expected();
    checks++;
    if (obs_rv2 !== 1'b1 || obs_bin !== 10'd511 || obs_right !== 28'd0 ||
        obs_left !== exp_left || obs_freq !== exp_freq) begin
      errors++;
      $display("FAIL edge_511 got rv=%b bin=%0d right=%h left=%h hz=%0d expected 1 511 0 %h %0d",
               obs_rv2, obs_bin, obs_right, obs_left, obs_freq, exp_left, exp_freq);
    end
  endtask

  task automatic test_errors();
    int rv0;
    rv0 = g_rv_count;
    for (int b = 0; b < 300; b++) drive(1'b1, 10'(b), (b == 150) ? 28'hFFFFFFF : 28'h10);
    drive(1'b1, 10'd301, 28'h10);
    drive(1'b0, 10'd0, 28'd0);
    checks++;
    if (o_frame_error !== 1'b1) begin
      errors++;
      $display("FAIL skip_error got fe=%b expected 1", o_frame_error);
    end
    drive(1'b1, 10'd302, 28'h10);
    drive(1'b0, 10'd0, 28'd0);
    checks++;
    if (o_frame_error !== 1'b0 || o_busy !== 1'b0) begin
      errors++;
      $display("FAIL skip_idle got fe=%b busy=%b expected 0 0", o_frame_error, o_busy);
    end
    repeat (4) drive(1'b0, 10'd0, 28'd0);
    checks++;
    if (g_rv_count !== rv0 ||
        {o_peak_bin, o_peak_mag, o_left_mag, o_right_mag, o_peak_freq_hz, o_peak_found} !==
        {exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found}) begin
      errors++;
      $display("FAIL skip_held got rv_count=%0d bin=%0d peak=%h expected %0d %0d %h",
               g_rv_count - rv0, o_peak_bin, o_peak_mag, 0, exp_bin, exp_peak);
    end
    for (int b = 0; b < 500; b++) drive(1'b1, 10'(b), (b == 100) ? 28'hFFFFFFF : 28'h20);
    for (int b = 0; b < 1024; b++) fr[b] = 28'($urandom_range(0, 32'h7FFFFFF));
    drive(1'b1, 10'd0, fr[0]);
    drive(1'b0, 10'd0, 28'd0);
    checks++;
    if (o_frame_error !== 1'b1 || o_busy !== 1'b1) begin
      errors++;
      $display("FAIL restart_error got fe=%b busy=%b expected 1 1", o_frame_error, o_busy);
    end
    run_frame(1, 1);
    compute_expected();
    checks++;
    if (obs_rv2 !== 1'b1 || g_rv_count !== rv0 + 1 || g_viol !== 0 ||
        {obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found} !==
        {exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found}) begin
      errors++;
      $display("FAIL restart_result got rv=%b rv_count=%0d viol=%0d bin=%0d peak=%h left=%h right=%h expected 1 1 0 %0d %h %h %h",
               obs_rv2, g_rv_count - rv0, g_viol, obs_bin, obs_peak, obs_left, obs_right,
               exp_bin, exp_peak, exp_left, exp_right);
    end
  endtask

  task automatic test_midreset();
    for (int b = 0; b <= 600; b++) drive(1'b1, 10'(b), 28'($urandom()));
    @(posedge clk);
    #2;
    rst = 1'b1;
    u_if.magnitude_valid = 1'b0;
    #1;
    checks++;
    if ({o_peak_bin, o_peak_mag, o_left_mag, o_right_mag, o_peak_freq_hz, o_peak_found,
         o_result_valid, o_frame_error, o_busy} !== 125'd0) begin
      errors++;
      $display("FAIL midreset_zero got bin=%0d mag=%h busy=%b expected all zero",
               o_peak_bin, o_peak_mag, o_busy);
    end
    @(negedge clk);
    rst = 1'b0;
    for (int b = 0; b < 1024; b++) fr[b] = 28'($urandom());
    run_frame(2, 0);
    compute_expected();
    checks++;
    if ({obs_rv1, obs_rv2, obs_rv3} !== 3'b010 || g_viol !== 0 ||
        {obs_bin, obs_peak, obs_left, obs_right, obs_freq, obs_found} !==
        {exp_bin, exp_peak, exp_left, exp_right, exp_freq, exp_found}) begin
      errors++;
      $display("FAIL midreset_frame got rv=%b%b%b viol=%0d bin=%0d hz=%0d expected 010 0 %0d %0d",
               obs_rv1, obs_rv2, obs_rv3, g_viol, obs_bin, obs_freq, exp_bin, exp_freq);
    end
  endtask

  initial begin
    u_if.magnitude_valid = 1'b0;
    u_if.bin_index       = 10'd0;
    u_if.magnitude       = 28'd0;
    test_reset();
    test_basic();
    test_gaps();
    test_random();
    test_exclusion();
    test_ties_edge();
    test_errors();
    test_midreset();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3ms;
    $display("FAIL watchdog simulation exceeded time limit");
    $fatal(1);
  end

endmodule
